// File: rtl/mem_bus_arbiter.sv
// Two-client line arbiter: I-cache (client 0) and D-cache (client 1) onto one memory bus, plus invalidation broadcast.
// Latency: one IDLE arbitration cycle per line; request, write-data and read-response beats pass through combinationally.
// Backpressure: the owner sees m_reqack and drives m_respack directly; the non-owner sees reqack=0 and simply holds its request.
module mem_bus_arbiter #(
   parameter int unsigned              BUS_DATA_WIDTH = 64,
   parameter int unsigned              BUS_TAG_WIDTH  = 13,
   parameter int unsigned              BEATS          = 8,
   parameter int unsigned              WRITE_BIT      = 12,
   parameter logic                     WRITE_VAL      = 1'b0,
   parameter logic [BUS_TAG_WIDTH-1:0] INV_TAG        = 13'h800
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic                      c0_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] c0_req,
   input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
   output logic                      c0_reqack,
   output logic                      c0_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] c0_resp,
   output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
   input  logic                      c0_respack,

   input  logic                      c1_reqcyc,
   input  logic [BUS_DATA_WIDTH-1:0] c1_req,
   input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
   output logic                      c1_reqack,
   output logic                      c1_respcyc,
   output logic [BUS_DATA_WIDTH-1:0] c1_resp,
   output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
   input  logic                      c1_respack,

   output logic                      m_reqcyc,
   output logic [BUS_DATA_WIDTH-1:0] m_req,
   output logic [BUS_TAG_WIDTH-1:0]  m_reqtag,
   input  logic                      m_reqack,
   input  logic                      m_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0] m_resp,
   input  logic [BUS_TAG_WIDTH-1:0]  m_resptag,
   output logic                      m_respack
);

   localparam int unsigned       BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   // One bus beat as seen on a request port: valid, tag, payload.
   typedef struct packed {
      logic                      cyc;
      logic [BUS_TAG_WIDTH-1:0]  tag;
      logic [BUS_DATA_WIDTH-1:0] dat;
   } beat_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WDATA,
      ST_RDATA
   } state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              is_write_q, is_write_d;
   logic [BEAT_W-1:0] beat_q, beat_d;

   beat_t [1:0] cli_req;
   logic  [1:0] cli_respack;
   beat_t       own_req;
   logic        own_respack;
   logic        inv_vld;
   logic        grant_vld;
   logic        grant_id;

   // Per-client output vectors, fanned out to the named ports at the bottom.
   logic [1:0]                     reqack;
   logic [1:0]                     respcyc;
   logic [1:0][BUS_DATA_WIDTH-1:0] resp;
   logic [1:0][BUS_TAG_WIDTH-1:0]  resptag;
   logic                           bus_reqcyc;
   logic [BUS_DATA_WIDTH-1:0]      bus_req;
   logic [BUS_TAG_WIDTH-1:0]       bus_reqtag;
   logic                           bus_respack;

   assign cli_req[0]     = {c0_reqcyc, c0_reqtag, c0_req};
   assign cli_req[1]     = {c1_reqcyc, c1_reqtag, c1_req};
   assign cli_respack    = {c1_respack, c0_respack};
   assign own_req        = cli_req[owner_q];
   assign own_respack    = cli_respack[owner_q];

   // An invalidation is recognised purely by its tag; it may arrive in any state.
   assign inv_vld   = m_respcyc && (m_resptag == INV_TAG);

   // Round robin: on a tie the client that did not win last time goes next.
   assign grant_vld = c0_reqcyc | c1_reqcyc;
   assign grant_id  = (c0_reqcyc && c1_reqcyc) ? ~last_grant_q : c1_reqcyc;

   // State register; reset abandons any line in flight and makes client 0 win the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         is_write_q   <= 1'b0;
         beat_q       <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         is_write_q   <= is_write_d;
         beat_q       <= beat_d;
      end
   end

   // Next-state and output routing: owner passthrough per state, then invalidation override, then reset blanking.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      is_write_d   = is_write_q;
      beat_d       = beat_q;

      reqack       = '0;
      respcyc      = '0;
      resp         = '0;
      resptag      = '0;
      bus_reqcyc   = 1'b0;
      bus_req      = '0;
      bus_reqtag   = '0;
      bus_respack  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               owner_d      = grant_id;
               last_grant_d = grant_id;
               is_write_d   = (cli_req[grant_id].tag[WRITE_BIT] == WRITE_VAL);
               beat_d       = '0;
               state_d      = ST_REQ;
            end
         end

         ST_REQ: begin
            bus_reqcyc      = own_req.cyc;
            bus_req         = own_req.dat;
            bus_reqtag      = own_req.tag;
            reqack[owner_q] = m_reqack;
            if (own_req.cyc && m_reqack) begin
               state_d = is_write_q ? ST_WDATA : ST_RDATA;
            end
         end

         ST_WDATA: begin
            bus_reqcyc      = own_req.cyc;
            bus_req         = own_req.dat;
            bus_reqtag      = own_req.tag;
            reqack[owner_q] = m_reqack;
            if (own_req.cyc && m_reqack) begin
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  beat_d  = beat_q + BEAT_W'(1);
               end
            end
         end

         ST_RDATA: begin
            // An invalidation beat borrows the response channel for one cycle and is not a data beat.
            if (!inv_vld) begin
               respcyc[owner_q] = m_respcyc;
               resp[owner_q]    = m_resp;
               resptag[owner_q] = m_resptag;
               bus_respack      = own_respack;
               if (m_respcyc && own_respack) begin
                  if (beat_q == LAST_BEAT) begin
                     beat_d  = '0;
                     state_d = ST_IDLE;
                  end else begin
                     beat_d  = beat_q + BEAT_W'(1);
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Invalidations go to both caches and are always consumed by the arbiter itself.
      if (inv_vld) begin
         respcyc     = 2'b11;
         resp[0]     = m_resp;
         resp[1]     = m_resp;
         resptag[0]  = INV_TAG;
         resptag[1]  = INV_TAG;
         bus_respack = 1'b1;
      end

      // Nothing leaves the block while reset is held, including from the cycle it is first asserted.
      if (reset) begin
         reqack      = '0;
         respcyc     = '0;
         resp        = '0;
         resptag     = '0;
         bus_reqcyc  = 1'b0;
         bus_req     = '0;
         bus_reqtag  = '0;
         bus_respack = 1'b0;
      end
   end

   assign c0_reqack  = reqack[0];
   assign c0_respcyc = respcyc[0];
   assign c0_resp    = resp[0];
   assign c0_resptag = resptag[0];
   assign c1_reqack  = reqack[1];
   assign c1_respcyc = respcyc[1];
   assign c1_resp    = resp[1];
   assign c1_resptag = resptag[1];
   assign m_reqcyc   = bus_reqcyc;
   assign m_req      = bus_req;
   assign m_reqtag   = bus_reqtag;
   assign m_respack  = bus_respack;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-client arbiter between the instruction cache (client 0) and data cache (client 1) and the single system memory bus. It serializes whole line transactions: one request beat, then eight write-data beats or eight read-response beats. It routes read responses back to the owning client and broadcasts invalidation beats to both clients.

## Interface
- BUS_DATA_WIDTH, 64, address/data beat width
- BUS_TAG_WIDTH, 13, request/response tag width
- BEATS, 8, data beats per line (512/64)
- WRITE_BIT, 12, tag bit index carrying the request type
- WRITE_VAL, 1'b0, value of tag[WRITE_BIT] meaning write
- INV_TAG, 13'h800, response tag marking an invalidation beat
- Clocking: clock clk; reset reset, synchronous, active-high
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cN_reqcyc  in  1  client N (N=0,1) request/write-data valid
- cN_req  in  64  client N address (request beat) or write data
- cN_reqtag  in  13  client N tag
- cN_reqack  out  1  beat accepted for client N
- cN_respcyc  out  1  response beat valid to client N
- cN_resp  out  64  response data to client N
- cN_resptag  out  13  response tag to client N
- cN_respack  in  1  client N accepts response beat
- m_reqcyc, m_req, m_reqtag  out  1/64/13  bus request
- m_reqack  in  1  bus accepts request beat
- m_respcyc, m_resp, m_resptag  in  1/64/13  bus response
- m_respack  out  1  response beat accepted

## Operation
- State: IDLE, REQ, WDATA, RDATA. Registers: owner (1b), last_grant (1b), is_write (1b), beat (3b).
- IDLE: no bus drive. If any cN_reqcyc=1, grant exactly one client. With both asserted, grant the client != last_grant (round robin). Register owner, last_grant<=owner, is_write<=(reqtag[WRITE_BIT]==WRITE_VAL), beat<=0. Go to REQ.
- REQ: m_reqcyc/m_req/m_reqtag = owner's inputs (combinational). owner reqack = m_reqack. On m_reqack=1: go to WDATA if is_write, else RDATA.
- WDATA: same passthrough of owner's cyc/data/tag to bus; owner reqack = m_reqack. Each cycle with m_reqcyc&m_reqack counts a beat; after beat 7 is accepted, go to IDLE.
- RDATA: owner respcyc/resp/resptag = bus response; m_respack = owner respack. Each cycle with m_respcyc&respack (tag != INV_TAG) counts a beat; after beat 7, go to IDLE.
- Non-owner client: reqack=0 and respcyc=0 always, except for invalidation beats. Its request waits; no request is lost or reordered.
- Invalidation: in any state, m_respcyc=1 with m_resptag==INV_TAG drives respcyc=1, resp=m_resp, resptag=INV_TAG to both clients for that cycle. The arbiter sets m_respack=1 itself. The beat is not counted and client respack is ignored. It preempts data routing for that cycle only.
- Beat counter wraps 7->0 only on the IDLE transition; it never exceeds 7.

## Timing
- All outputs 0 while reset=1 and in IDLE; state<=IDLE, last_grant<=1 (client 0 wins the first tie), owner/beat/is_write<=0.
- Reset mid-transaction aborts it with no completion; outputs 0 from the reset cycle on.
- Grant latency: a request seen in IDLE appears on the bus the next cycle (1-cycle arbitration bubble).
- All data/ack paths in REQ/WDATA/RDATA are combinational passthroughs (0 added latency per beat).
- A line transaction takes 1 (IDLE) + request beats + 8 data beats; back-to-back transactions have one IDLE cycle between them.
- Simultaneous m_reqack and state exit: the exit takes effect at the next edge; no beat is double-counted.

## Test plan
- Client 0 read of 0x1000, tag 13'h1000: bus sees m_req=0x1000 one cycle after c0_reqcyc. 8 response beats 0xA0..0xA7 arrive on c0_resp in order, c1_respcyc stays 0, return to IDLE after the 8th ack.
- Client 1 write of 0x2040, tag[12]=0, data 0xB0..0xB7 with m_reqack stalled 2 cycles per beat: bus receives exactly 8 data beats in order, c1_reqack mirrors m_reqack.
- Both clients request in the same cycle after reset: client 0 is granted first. After its read completes, client 1 is granted with one IDLE cycle between; then both again -> client 0 (round robin).
- Invalidation (resptag 13'h800, data 0x3000) during a client 0 read, mid beat 3: both clients see respcyc for 1 cycle, m_respack=1, beat count stays 3, and the read completes with 8 beats.
- Reset asserted during WDATA beat 4: all outputs 0 next cycle, state IDLE. A new client 1 request is then served from its request beat.
